// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - program memory, PC sequencer and valid/ready IR issue to the core
module instr_issue_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          halt,
    output logic [IW-1:0] ir_out,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [AW-1:0] pc,
    output logic [AW:0]   issued_cnt,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [IW-1:0] r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [IW-1:0] r_ir;
    logic          r_valid;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_len;
    logic          r_err;

    logic w_busy;
    logic w_len_ok;
    logic w_accept;
    logic w_last;

    assign w_busy   = (r_state == S_FETCH) || (r_state == S_ISSUE);
    assign w_len_ok = (prog_len != '0) && (prog_len <= DEPTH_L);
    assign w_accept = (r_state == S_ISSUE) && r_valid && ir_ready;
    assign w_last   = ({1'b0, r_pc} == (r_len - 1'b1));

    // Writes are only taken while no run is in progress, so an active program is never altered.
    always_ff @(posedge clk) begin
        if (load_en && !w_busy) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= load_en && w_busy;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= prog_len;
                            r_pc    <= '0;
                            r_cnt   <= '0;
                            r_state <= S_FETCH;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (halt) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ir    <= r_mem[r_pc];
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An accept coinciding with halt still counts before the run is aborted.
                    if (w_accept) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_valid <= 1'b0;
                        if (halt) begin
                            r_state <= S_IDLE;
                        end else if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else if (halt) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ir_out     = r_ir;
    assign ir_valid   = r_valid;
    assign pc         = r_pc;
    assign issued_cnt = r_cnt;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - scoreboard bench for instr_issue_unit
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        halt;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic [3:0]  pc;
    logic [4:0]  issued_cnt;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int n_acc  = 0;
    int n_done = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_model [16];

    instr_issue_unit #(.DEPTH(16), .AW(4), .IW(32)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .halt(halt),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .pc(pc), .issued_cnt(issued_cnt), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is popped against the scoreboard queue
    always @(negedge clk) begin
        if (!sys_rst && ir_valid && ir_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue_unexpected actual=%h required=none", ir_out);
            end else begin
                check("issue_word", 64'(ir_out), 64'(exp_q.pop_front()));
            end
        end
        if (!sys_rst && done) n_done++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        if (!busy) mem_model[a] = d;
        tick;
        load_en = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        prog_len = len; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic push_prog(input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mem_model[i]);
    endtask

    task automatic wait_valid;
        int k;
        k = 0;
        while (!ir_valid && k < 20) begin
            tick;
            k++;
        end
        if (!ir_valid) check("wait_valid_timeout", 64'(ir_valid), 64'd1);
    endtask

    task automatic finish_run;
        int k;
        k = 0;
        while (!done && k < 200) begin
            tick;
            k++;
        end
        if (!done) check("wait_done_timeout", 64'(done), 64'd1);
        tick;
    endtask

    int d0, a0;

    initial begin
        sys_rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; halt = 1'b0; ir_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem_model[i] = 'x;
        tick; tick;
        check("reset_outputs", {ir_out, ir_valid, pc, issued_cnt, busy, done, err}, 64'd0);
        sys_rst = 1'b0;
        tick;

        load(4'd0, 32'h1005_0004);
        load(4'd1, 32'h0901_0037);

        // Basic two-instruction run with ready always high
        ir_ready = 1'b1;
        push_prog(2);
        d0 = n_done;
        do_start(5'd2);
        check("t1_fetch_busy", {ir_valid, busy}, 64'b01);
        tick;
        check("t1_first_valid", {ir_valid, ir_out}, {1'b1, 32'h1005_0004});
        finish_run;
        check("t1_issued_cnt", 64'(issued_cnt), 64'd2);
        check("t1_final_pc", 64'(pc), 64'd1);
        check("t1_done_once", 64'(n_done - d0), 64'd1);
        check("t1_idle", {busy, done, ir_valid}, 64'd0);

        // Backpressure: word must hold while ready is low
        ir_ready = 1'b0;
        push_prog(2);
        do_start(5'd2);
        wait_valid;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold", {ir_valid, ir_out}, {1'b1, 32'h1005_0004});
            tick;
        end
        check("t2_no_accept_yet", 64'(issued_cnt), 64'd0);
        a0 = n_acc;
        ir_ready = 1'b1;
        finish_run;
        check("t2_accepts", 64'(n_acc - a0), 64'd2);
        check("t2_issued_cnt", 64'(issued_cnt), 64'd2);

        // Illegal lengths
        do_start(5'd0);
        check("t3_len0_err", {err, busy, ir_valid}, 64'b100);
        tick;
        check("t3_err_pulse", 64'(err), 64'd0);
        do_start(5'd17);
        check("t3_len17_err", {err, busy, ir_valid}, 64'b100);
        tick;
        check("t3_still_idle", {err, busy, ir_valid}, 64'd0);

        // Load while busy is dropped and flagged
        ir_ready = 1'b0;
        push_prog(2);
        do_start(5'd2);
        wait_valid;
        load(4'd1, 32'hFFFF_FFFF);
        check("t4_busy_load_err", 64'(err), 64'd1);
        ir_ready = 1'b1;
        finish_run;
        check("t4_issued_cnt", 64'(issued_cnt), 64'd2);

        // Full-depth run
        for (int i = 0; i < 16; i++) load(4'(i), 32'hA000_0000 + 32'(i) * 32'h0011_0001);
        push_prog(16);
        d0 = n_done;
        a0 = n_acc;
        do_start(5'd16);
        finish_run;
        check("t5_final_pc", 64'(pc), 64'd15);
        check("t5_issued_cnt", 64'(issued_cnt), 64'd16);
        check("t5_accepts", 64'(n_acc - a0), 64'd16);
        check("t5_done_once", 64'(n_done - d0), 64'd1);

        // Halt while the second instruction waits
        ir_ready = 1'b0;
        exp_q.push_back(mem_model[0]);
        d0 = n_done;
        do_start(5'd2);
        wait_valid;
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        wait_valid;
        halt = 1'b1;
        tick;
        halt = 1'b0;
        check("t6_halt_valid_busy", {ir_valid, busy}, 64'd0);
        check("t6_halt_cnt", 64'(issued_cnt), 64'd1);
        tick; tick;
        check("t6_no_done", 64'(n_done - d0), 64'd0);

        // Asynchronous reset mid-run
        do_start(5'd16);
        tick; tick; tick;
        sys_rst = 1'b1;
        #1;
        check("t7_async_reset", {ir_out, ir_valid, pc, issued_cnt, busy, done, err}, 64'd0);
        tick;
        sys_rst = 1'b0;
        tick;
        check("t7_stays_idle", {ir_valid, busy}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
